// File: rtl/divider_8_by_4_bit_unsigned_v_if.sv
// Handshake and operand/result bundle for the 8-by-4 unsigned divider.
// Nibble split of dividend and quotient matches the 4-bit multiplier product.
interface divider_8_by_4_bit_unsigned_v_if;
  logic       i_start;
  logic [3:0] i_nu0;
  logic [3:0] i_nu1;
  logic [3:0] i_du;
  logic       o_busy;
  logic       o_done;
  logic       o_div_zero;
  logic [3:0] o_qu0;
  logic [3:0] o_qu1;
  logic [3:0] o_ru;

  modport master (
    output i_start, i_nu0, i_nu1, i_du,
    input  o_busy, o_done, o_div_zero, o_qu0, o_qu1, o_ru
  );

  modport slave (
    input  i_start, i_nu0, i_nu1, i_du,
    output o_busy, o_done, o_div_zero, o_qu0, o_qu1, o_ru
  );
endinterface

// File: rtl/divider_8_by_4_bit_unsigned_v.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock MSB first, with start/busy/done handshake and divide-by-zero path.
module divider_8_by_4_bit_unsigned_v #(
  parameter logic [7:0] DZ_QUOTIENT  = 8'hFF,
  parameter logic [3:0] DZ_REMAINDER = 4'hF
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  divider_8_by_4_bit_unsigned_v_if.slave bus
);

  localparam int unsigned NW = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n_q;
  logic [NW-1:0] q_acc;
  logic [NW-1:0] q_nxt;
  logic [DW-1:0] d_q;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_nxt;
  logic [DW:0]   r_shift;
  logic          r_ge;

  logic          busy_q;
  logic          done_q;
  logic          dz_q;
  logic [NW-1:0] qu_q;
  logic [DW-1:0] ru_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; a zero divisor skips RUN entirely
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nxt = (bus.i_du != '0) ? S_RUN : S_DONE;
      S_RUN:   if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step: the 5th remainder bit only feeds the compare
  always_comb begin
    r_shift = {r_q, n_q[cnt]};
    r_ge    = (r_shift >= {1'b0, d_q});
    r_nxt   = r_ge ? DW'(r_shift - {1'b0, d_q}) : r_shift[DW-1:0];
    q_nxt   = q_acc;
    q_nxt[cnt] = r_ge;
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      q_acc  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      qu_q   <= '0;
      ru_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            n_q   <= {bus.i_nu1, bus.i_nu0};
            d_q   <= bus.i_du;
            cnt   <= CW'(NW - 1);
            r_q   <= '0;
            q_acc <= '0;
            if (bus.i_du == '0) begin
              qu_q   <= DZ_QUOTIENT;
              ru_q   <= DZ_REMAINDER;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_q   <= r_nxt;
          q_acc <= q_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            qu_q   <= q_nxt;
            ru_q   <= r_nxt;
            dz_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_div_zero = dz_q;
  assign bus.o_qu0      = qu_q[3:0];
  assign bus.o_qu1      = qu_q[7:4];
  assign bus.o_ru       = ru_q;

endmodule

// File: tb/tb_divider_8_by_4_bit_unsigned_v.sv
// Self-checking bench for the 8-by-4 divider: cycle-level arithmetic model,
// per-cycle output compare, directed boundary cases, random and exhaustive sweeps.
module tb_divider_8_by_4_bit_unsigned_v;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  divider_8_by_4_bit_unsigned_v_if bus ();

  divider_8_by_4_bit_unsigned_v #(
    .DZ_QUOTIENT (8'hFF),
    .DZ_REMAINDER(4'hF)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state (timing expressed as cycle numbers, results by arithmetic)
  int         cyc        = 0;
  bit         m_active   = 1'b0;
  int         m_done_cyc = 0;
  int         m_next_ok  = 0;
  logic       m_busy     = 1'b0;
  logic       m_done     = 1'b0;
  logic       m_dz       = 1'b0;
  logic [7:0] m_q        = '0;
  logic [3:0] m_r        = '0;
  logic [7:0] p_n        = '0;
  logic [3:0] p_d        = '0;
  logic [7:0] p_q        = '0;
  logic [3:0] p_r        = '0;
  logic       p_dz       = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_done = 1'b0;
      if (!rst_n) begin
        m_active  = 1'b0;
        m_busy    = 1'b0;
        m_dz      = 1'b0;
        m_q       = '0;
        m_r       = '0;
        m_next_ok = 0;
      end else begin
        if (!m_active && bus.i_start && cyc >= m_next_ok) begin
          p_n      = {bus.i_nu1, bus.i_nu0};
          p_d      = bus.i_du;
          m_active = 1'b1;
          if (p_d == 4'd0) begin
            p_q = 8'hFF; p_r = 4'hF; p_dz = 1'b1;
            m_done_cyc = cyc;
          end else begin
            p_q = p_n / 8'(p_d);
            p_r = 4'(p_n % 8'(p_d));
            p_dz = 1'b0;
            m_done_cyc = cyc + 8;
            m_busy = 1'b1;
          end
          m_next_ok = m_done_cyc + 2;
        end
        if (m_active && cyc == m_done_cyc) begin
          m_active = 1'b0;
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, plus the N = q*D + r invariant at done
  initial begin
    logic [22:0] act, expv;
    int lhs;
    forever begin
      @(negedge clk);
      act = {bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_qu1, bus.o_qu0, bus.o_ru};
      if (!rst_n) expv = '0;
      else        expv = {m_busy, m_done, m_dz, m_q, m_r};
      n_tests++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle_check cyc=%0d got busy=%b done=%b dz=%b q=%h r=%h expected busy=%b done=%b dz=%b q=%h r=%h",
                 cyc, act[22], act[21], act[20], act[19:12], act[11:8],
                 expv[22], expv[21], expv[20], expv[19:12], expv[11:8]);
      end
      if (rst_n && bus.o_done && !bus.o_div_zero && p_d != 4'd0) begin
        lhs = int'({bus.o_qu1, bus.o_qu0}) * int'(p_d) + int'(bus.o_ru);
        n_tests++;
        if (lhs != int'(p_n) || bus.o_ru >= p_d) begin
          n_fail++;
          $display("FAIL invariant N=%0d D=%0d got q=%0d r=%0d (q*D+r=%0d)",
                   p_n, p_d, {bus.o_qu1, bus.o_qu0}, bus.o_ru, lhs);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic do_div(input logic [7:0] n, input logic [3:0] d,
                        output logic [7:0] q, output logic [3:0] r, output logic dz);
    bit seen;
    seen = 1'b0;
    @(negedge clk); #1;
    bus.i_nu0 = n[3:0]; bus.i_nu1 = n[7:4]; bus.i_du = d; bus.i_start = 1'b1;
    @(negedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_nu0 = 4'($urandom); bus.i_nu1 = 4'($urandom); bus.i_du = 4'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout N=%0d D=%0d got no done expected done within 20 cycles", n, d);
    end
    q  = {bus.o_qu1, bus.o_qu0};
    r  = bus.o_ru;
    dz = bus.o_div_zero;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    bus.i_start = 1'b0;
    bus.i_nu0 = '0; bus.i_nu1 = '0; bus.i_du = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed boundary cases with hand-computed results
    do_div(8'd200, 4'd7, q, r, dz);
    chk("q_200_7", int'(q), 'h1C); chk("r_200_7", int'(r), 4); chk("dz_200_7", int'(dz), 0);
    do_div(8'd225, 4'd15, q, r, dz);
    chk("q_225_15", int'(q), 'h0F); chk("r_225_15", int'(r), 0);
    do_div(8'd255, 4'd1, q, r, dz);
    chk("q_255_1", int'(q), 'hFF); chk("r_255_1", int'(r), 0);
    do_div(8'd5, 4'd9, q, r, dz);
    chk("q_5_9", int'(q), 0); chk("r_5_9", int'(r), 5);
    do_div(8'h3A, 4'd0, q, r, dz);
    chk("q_dz", int'(q), 'hFF); chk("r_dz", int'(r), 'hF); chk("dz_flag", int'(dz), 1);
    do_div(8'd10, 4'd3, q, r, dz);
    chk("q_10_3", int'(q), 3); chk("r_10_3", int'(r), 1); chk("dz_clear", int'(dz), 0);

    // Start held high with operands changing every cycle
    @(negedge clk); #1;
    bus.i_start = 1'b1;
    repeat (40) begin
      bus.i_nu0 = 4'($urandom); bus.i_nu1 = 4'($urandom);
      bus.i_du  = 4'($urandom_range(0, 15));
      @(negedge clk); #1;
    end
    bus.i_start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset dropped in the middle of a division
    #1;
    bus.i_nu0 = 4'h8; bus.i_nu1 = 4'hC; bus.i_du = 4'd7; bus.i_start = 1'b1;
    @(negedge clk); #1;
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_div(8'd100, 4'd6, q, r, dz);
    chk("q_after_rst", int'(q), 16); chk("r_after_rst", int'(r), 4);

    // Random operands including zero divisors
    repeat (150) do_div(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), q, r, dz);

    // Exhaustive nonzero-divisor sweep
    for (int d = 1; d < 16; d++)
      for (int n = 0; n < 256; n++)
        do_div(8'(n), 4'(d), q, r, dz);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
